sub8_serial: RTL and testbench
==============================

SUB8_SERIAL -- requirements
Module: sub8_serial

Interface
REQ-001 Parameter WIDTH: default 8; operand width. Input c is WIDTH+1 bits; b and a are WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  c/b operand pair is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 c  input  WIDTH+1  minuend; the sum word produced by the adder8 block.
REQ-007 b  input  WIDTH  subtrahend; zero-extended to WIDTH+1 internally.
REQ-008 out_valid  output  1  result a is valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 a  output  WIDTH  recovered operand, a = (c - b) mod 2^WIDTH.
REQ-011 err  output  1  present only with SUB8_RANGE_CHECK_EN; set when the true difference c - b lies outside 0..2^WIDTH-1.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE with in_valid=1, the rising edge (E0) latches c and the zero-extended b into shift registers, clears the borrow, sets the bit counter to 0, and moves to SHIFT.
REQ-015 Each SHIFT edge processes one bit, LSB first: diff bit = c_i ^ b_i ^ borrow; borrow_next = (~c_i & b_i) | (~(c_i ^ b_i) & borrow); the counter increments.
REQ-016 SHIFT lasts exactly WIDTH+1 edges; on the (WIDTH+1)th edge (E9 at default WIDTH), the state moves to DONE and the result and flags register. out_valid is therefore first high in the cycle after E9.
REQ-017 a SHALL equal the low WIDTH bits of the (WIDTH+1)-bit difference.
REQ-018 The final borrow and the difference MSB are held for the err computation.
REQ-019 In DONE, a (and err) SHALL hold stable until out_valid and out_ready are both 1; that edge returns the FSM to IDLE.
REQ-020 No acceptance is possible in the cycle in which DONE is exited; in_ready rises the cycle after.
REQ-021 in_valid in SHIFT or DONE is ignored; c and b may change freely outside IDLE.
REQ-022 out_ready while not in DONE has no effect.
REQ-023 Throughput: one result per WIDTH+3 cycles minimum (accept, WIDTH+1 SHIFT, DONE).

Reset
REQ-024 With rst_n=0 at a rising edge: state becomes IDLE, and a, err, the shift registers, borrow, and counter become 0. out_valid=0 and in_ready=1 from the following cycle.
REQ-025 Reset in SHIFT or DONE SHALL abort the operation with no result delivered; the next accepted pair starts clean.
REQ-026 Reset overrides simultaneous in_valid/out_ready.

Configuration
REQ-027 Macro SUB8_RANGE_CHECK_EN defined: port err exists and is registered together with a, with err = final borrow | difference bit WIDTH. err is 0 at reset.
REQ-028 Macro SUB8_RANGE_CHECK_EN undefined: port err and its logic are absent; all other behaviour is identical.

Verification
REQ-029 c=11, b=10, out_ready=1 -> out_valid high in the cycle after the 9th SHIFT edge, with a=1 and err=0.
REQ-030 c=510, b=255 -> a=255, err=0; c=0, b=0 -> a=0, err=0.
REQ-031 c=0, b=1 -> a=255, err=1 (borrow); c=300, b=10 -> a=34, err=1 (difference above 255).
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> a is stable and out_valid stays high; in_valid pulses are ignored. out_ready=1 -> IDLE, and in_ready rises the following cycle.
REQ-033 rst_n=0 on the 4th SHIFT edge of c=165, b=66 -> IDLE, no out_valid. A new pair c=99, b=3 then gives a=96.
REQ-034 Back-to-back pairs with in_valid held high -> a result per 11 cycles. Checks: in_ready and out_valid are never both 1, and every result matches (c-b) mod 256.

Source files
------------

// File: rtl/sub8_serial.sv
// Bit-serial subtractor: recovers a = (c - b) mod 2^WIDTH one bit per cycle, LSB first.
// Optional range flag err is compiled in with SUB8_RANGE_CHECK_EN.
module sub8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   c,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a
`ifdef SUB8_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_next;
  logic [WIDTH:0] c_sh, b_sh, d_sh;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic           dbit, borrow_nx, last_bit;

  assign dbit      = c_sh[0] ^ b_sh[0] ^ borrow;
  assign borrow_nx = (~c_sh[0] & b_sh[0]) | (~(c_sh[0] ^ b_sh[0]) & borrow);
  assign last_bit  = (cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Difference bits enter at the top of d_sh, so after WIDTH+1 shifts it holds the full word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a      <= '0;
`ifdef SUB8_RANGE_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_sh   <= c;
            b_sh   <= {1'b0, b};
            d_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          c_sh   <= c_sh >> 1;
          b_sh   <= b_sh >> 1;
          d_sh   <= {dbit, d_sh[WIDTH:1]};
          borrow <= borrow_nx;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            a <= d_sh[WIDTH:1];
`ifdef SUB8_RANGE_CHECK_EN
            err <= borrow_nx | dbit;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub8_serial.sv
// Scoreboard bench for sub8_serial: accepted pairs push an arithmetic model result,
// a negedge monitor pops and compares on every presented result.
module tb_sub8_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W:0]   c = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] a;
`ifdef SUB8_RANGE_CHECK_EN
  logic         err;
`endif

  sub8_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .b(b), .out_valid(out_valid), .out_ready(out_ready), .a(a)
`ifdef SUB8_RANGE_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic         err;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = -1;
  bit   rand_or = 1'b0;
  bit   b2b = 1'b0;
  bit   prev_ov = 1'b0;
  bit   prev_hs = 1'b0;

  function automatic exp_t model(int cv, int bv, int acc);
    exp_t m;
    int   d = cv - bv;
    int   md = 1 << W;
    m.a   = W'(((d % md) + md) % md);
    m.err = (d < 0) || (d >= md);
    m.acc = acc;
    return m;
  endfunction

  task automatic chk(bit ok, string name, int act, int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = ($urandom % 2) == 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      chk(!(in_ready && out_valid), "ready_valid_exclusive", int'({in_ready, out_valid}), 0);
      if (prev_hs) chk(in_ready && !out_valid, "in_ready_after_handshake", int'(in_ready), 1);
      if (in_valid && in_ready) begin
        q.push_back(model(int'(c), int'(b), cyc));
        if (b2b) begin
          if (last_acc >= 0) chk(cyc - last_acc == W + 3, "b2b_interval", cyc - last_acc, W + 3);
          last_acc = cyc;
        end
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_out_valid", 1, 0);
        end else begin
          if (!prev_ov) chk(cyc - q[0].acc == W + 2, "latency", cyc - q[0].acc, W + 2);
          chk(a == q[0].a, "result_a", int'(a), int'(q[0].a));
`ifdef SUB8_RANGE_CHECK_EN
          chk(err == q[0].err, "result_err", int'(err), int'(q[0].err));
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = out_valid && !out_ready;
      prev_hs = out_valid && out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int cv, int bv);
    bit rdy;
    int i;
    c = (W+1)'(cv);
    b = W'(bv);
    in_valid = 1'b1;
    for (i = 0; i < 100; i++) begin
      rdy = in_ready && rst_n;
      tick();
      if (rdy) break;
    end
    if (i == 100) chk(1'b0, "accept_timeout", 0, 1);
    in_valid = 1'b0;
    c = (W+1)'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400; i++) begin
      if (q.size() == 0 && in_ready) break;
      tick();
    end
    if (i == 400) chk(1'b0, "drain_timeout", q.size(), 0);
  endtask

  initial begin
    int i;
    tick();
    tick();
    @(negedge clk);
    chk(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
    chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    chk(a == '0, "reset_a", int'(a), 0);
    tick();
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    send(11, 10);
    drain();
    send(510, 255);
    send(0, 0);
    send(0, 1);
    send(300, 10);
    drain();

    out_ready = 1'b0;
    send(200, 55);
    for (i = 0; i < 50; i++) begin
      if (out_valid) break;
      tick();
    end
    if (i == 50) chk(1'b0, "bp_wait_timeout", 0, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      c = (W+1)'($urandom);
      b = W'($urandom);
      tick();
      chk(out_valid == 1'b1, "bp_out_valid_hold", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    drain();

    send(165, 66);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1, "abort_in_ready", int'(in_ready), 1);
    chk(out_valid == 1'b0, "abort_out_valid", int'(out_valid), 0);
    chk(a == '0, "abort_a_cleared", int'(a), 0);
    tick();
    repeat (15) tick();
    send(99, 3);
    drain();

    out_ready = 1'b1;
    last_acc = -1;
    b2b = 1'b1;
    in_valid = 1'b1;
    repeat (12 * (W + 3)) begin
      c = (W+1)'($urandom);
      b = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    drain();

    rand_or = 1'b1;
    repeat (40) begin
      send(int'($urandom_range(0, (1 << (W + 1)) - 1)), int'($urandom_range(0, (1 << W) - 1)));
      repeat ($urandom_range(0, 4)) tick();
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
